// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game-flow sequencer and its frame timer.
package game_flow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BANNER = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_DYING  = 3'd4,
        ST_WON    = 3'd5,
        ST_LOST   = 3'd6
    } state_t;

    localparam int         STAGE_W    = 3;
    localparam int         LIVES_W    = 2;
    localparam logic [2:0] STAGE_NONE = 3'd0;

    // Counter width able to hold the larger of the two interlude lengths (never below 1).
    function automatic int timer_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/game_flow_sequencer_frame_timer.sv
// Frame-counting interlude timer: reloaded per banner/respawn, counts start_frame pulses.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         start_frame,
    output logic         done
);

    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_r;

    // Count register: load N-1 (N=0 behaves like N=1), then step down once per frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= (value == ZERO) ? ZERO : (value - ONE);
        end else if (start_frame && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = start_frame && (count_r == ZERO);

endmodule

// File: rtl/game_flow_sequencer.sv
// Game-flow sequencer: stage, lives, pause and frame-timed interludes with registered Moore outputs.
module game_flow_sequencer
    import game_flow_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int LIVES_INIT     = 3,
    parameter int BANNER_FRAMES  = 120,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_frame,
    input  logic       start_game,
    input  logic       pause_sw,
    input  logic       win_stage,
    input  logic       player_hit,
    output logic [2:0] stage_num,
    output logic [1:0] lives,
    output logic       enable_play,
    output logic       show_banner,
    output logic       clear_objects,
    output logic       game_won,
    output logic       game_over
);

    localparam int                 TW         = timer_width(BANNER_FRAMES, RESPAWN_FRAMES);
    localparam logic [TW-1:0]      BANNER_N   = TW'(BANNER_FRAMES);
    localparam logic [TW-1:0]      RESPAWN_N  = TW'(RESPAWN_FRAMES);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES);
    localparam logic [LIVES_W-1:0] LIVES_RST  = LIVES_W'(LIVES_INIT);

    state_t             state_r, state_s;
    logic               hist_r;
    logic               armed_r;
    logic               start_rise_s;
    logic [STAGE_W-1:0] stage_r, stage_s;
    logic [LIVES_W-1:0] lives_r, lives_s;
    logic               clear_r, clear_s;
    logic               enable_r, banner_r, won_r, over_r;
    logic               timer_load_s;
    logic [TW-1:0]      timer_val_s;
    logic               timer_done_s;

    // A switch already high when reset releases must be seen low before it can start a game.
    assign start_rise_s = start_game && !hist_r && armed_r;

    frame_timer #(.W(TW)) u_timer (
        .clk         (clk),
        .resetN      (resetN),
        .load        (timer_load_s),
        .value       (timer_val_s),
        .start_frame (start_frame),
        .done        (timer_done_s)
    );

    // State and registered output bank.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r  <= ST_IDLE;
            hist_r   <= 1'b0;
            armed_r  <= 1'b0;
            stage_r  <= STAGE_NONE;
            lives_r  <= LIVES_RST;
            clear_r  <= 1'b0;
            enable_r <= 1'b0;
            banner_r <= 1'b0;
            won_r    <= 1'b0;
            over_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            hist_r   <= start_game;
            armed_r  <= armed_r | ~start_game;
            stage_r  <= stage_s;
            lives_r  <= lives_s;
            clear_r  <= clear_s;
            enable_r <= (state_s == ST_PLAY);
            banner_r <= (state_s == ST_BANNER);
            won_r    <= (state_s == ST_WON);
            over_r   <= (state_s == ST_LOST);
        end
    end

    // Next-state, stage/lives update and timer reload decisions.
    always_comb begin
        state_s      = state_r;
        stage_s      = stage_r;
        lives_s      = lives_r;
        clear_s      = 1'b0;
        timer_load_s = 1'b0;
        timer_val_s  = BANNER_N;
        case (state_r)
            ST_IDLE: begin
                stage_s = STAGE_NONE;
                lives_s = LIVES_RST;
                if (start_rise_s) begin
                    state_s      = ST_BANNER;
                    stage_s      = 3'd1;
                    clear_s      = 1'b1;
                    timer_load_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BANNER: begin
                if (timer_done_s) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_BANNER;
                end
            end
            ST_PLAY: begin
                if (player_hit) begin
                    if (lives_r <= 2'd1) begin
                        state_s = ST_LOST;
                        lives_s = 2'd0;
                    end else begin
                        state_s      = ST_DYING;
                        lives_s      = lives_r - 2'd1;
                        clear_s      = 1'b1;
                        timer_load_s = 1'b1;
                        timer_val_s  = RESPAWN_N;
                    end
                end else if (win_stage) begin
                    if (stage_r >= LAST_STAGE) begin
                        state_s = ST_WON;
                    end else begin
                        state_s      = ST_BANNER;
                        stage_s      = stage_r + 3'd1;
                        clear_s      = 1'b1;
                        timer_load_s = 1'b1;
                    end
                end else if (pause_sw) begin
                    state_s = ST_PAUSE;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (!pause_sw) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_DYING: begin
                if (timer_done_s) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_DYING;
                end
            end
            ST_WON, ST_LOST: begin
                if (start_rise_s) begin
                    state_s      = ST_BANNER;
                    stage_s      = 3'd1;
                    lives_s      = LIVES_RST;
                    clear_s      = 1'b1;
                    timer_load_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                stage_s = STAGE_NONE;
                lives_s = LIVES_RST;
            end
        endcase
    end

    assign stage_num     = stage_r;
    assign lives         = lives_r;
    assign clear_objects = clear_r;
    assign enable_play   = enable_r;
    assign show_banner   = banner_r;
    assign game_won      = won_r;
    assign game_over     = over_r;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Randomized bench for game_flow_sequencer against a frame-counting reference model.
module tb_game_flow_sequencer;

    localparam int NS = 2;
    localparam int LI = 2;
    localparam int BF = 3;
    localparam int RF = 2;

    localparam int P_IDLE   = 0;
    localparam int P_BANNER = 1;
    localparam int P_PLAY   = 2;
    localparam int P_PAUSE  = 3;
    localparam int P_DYING  = 4;
    localparam int P_WON    = 5;
    localparam int P_LOST   = 6;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start_frame, start_game, pause_sw, win_stage, player_hit;
    logic [2:0] stage_num;
    logic [1:0] lives;
    logic       enable_play, show_banner, clear_objects, game_won, game_over;

    int checks = 0;
    int errors = 0;
    int resets_done = 0;

    int m_phase, m_stage, m_lives, m_frames_left;
    bit m_clear, m_prev, m_armed;

    game_flow_sequencer #(
        .NUM_STAGES(NS), .LIVES_INIT(LI), .BANNER_FRAMES(BF), .RESPAWN_FRAMES(RF)
    ) dut (
        .clk(clk), .resetN(resetN), .start_frame(start_frame), .start_game(start_game),
        .pause_sw(pause_sw), .win_stage(win_stage), .player_hit(player_hit),
        .stage_num(stage_num), .lives(lives), .enable_play(enable_play),
        .show_banner(show_banner), .clear_objects(clear_objects),
        .game_won(game_won), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic check_outputs();
        check_value("stage_num", int'(stage_num), m_stage);
        check_value("lives", int'(lives), m_lives);
        check_value("enable_play", int'(enable_play), int'(m_phase == P_PLAY));
        check_value("show_banner", int'(show_banner), int'(m_phase == P_BANNER));
        check_value("clear_objects", int'(clear_objects), int'(m_clear));
        check_value("game_won", int'(game_won), int'(m_phase == P_WON));
        check_value("game_over", int'(game_over), int'(m_phase == P_LOST));
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_stage = 0;
        m_lives = LI;
        m_clear = 1'b0;
        m_prev  = 1'b0;
        m_armed = 1'b0;
        m_frames_left = 0;
    endtask

    task automatic model_begin_game();
        m_phase = P_BANNER;
        m_stage = 1;
        m_lives = LI;
        m_clear = 1'b1;
        m_frames_left = BF;
    endtask

    // One clock of game rules applied to the inputs that the next rising edge samples.
    task automatic model_step(input bit sf, input bit sg, input bit ps, input bit ws, input bit ph);
        bit rise;
        rise = sg && !m_prev && m_armed;
        m_armed = m_armed || !sg;
        m_prev  = sg;
        m_clear = 1'b0;
        case (m_phase)
            P_IDLE: if (rise) model_begin_game();
            P_BANNER, P_DYING: begin
                if (sf) begin
                    if (m_frames_left <= 1) m_phase = P_PLAY;
                    else m_frames_left--;
                end
            end
            P_PLAY: begin
                if (ph) begin
                    if (m_lives == 1) begin
                        m_phase = P_LOST;
                        m_lives = 0;
                    end else begin
                        m_lives--;
                        m_clear = 1'b1;
                        m_phase = P_DYING;
                        m_frames_left = RF;
                    end
                end else if (ws) begin
                    if (m_stage == NS) begin
                        m_phase = P_WON;
                    end else begin
                        m_stage++;
                        m_clear = 1'b1;
                        m_phase = P_BANNER;
                        m_frames_left = BF;
                    end
                end else if (ps) begin
                    m_phase = P_PAUSE;
                end
            end
            P_PAUSE: if (!ps) m_phase = P_PLAY;
            P_WON, P_LOST: if (rise) model_begin_game();
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked before any clock edge.
    task automatic async_reset(input bit sg_level);
        resetN = 1'b0;
        #1;
        model_reset();
        check_outputs();
        start_game  = sg_level;
        start_frame = 1'b0;
        win_stage   = 1'b0;
        player_hit  = 1'b0;
        pause_sw    = 1'b0;
        @(posedge clk);
        #2;
        check_outputs();
        resetN = 1'b1;
    endtask

    initial begin
        resetN      = 1'b0;
        start_frame = 1'b0;
        start_game  = 1'b1;
        pause_sw    = 1'b0;
        win_stage   = 1'b0;
        player_hit  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        @(posedge clk);
        #2;
        resetN = 1'b1;

        // start_game held high through reset release must not start a game.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_outputs();
            start_frame = ($urandom_range(0, 1) == 0);
            model_step(start_frame, start_game, pause_sw, win_stage, player_hit);
        end

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            check_outputs();
            if (m_phase == P_BANNER && resets_done < 3 && $urandom_range(0, 3) == 0) begin
                resets_done++;
                async_reset(resets_done[0]);
            end else begin
                start_frame = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 19) == 0) start_game = ~start_game;
                if ($urandom_range(0, 29) == 0) pause_sw = ~pause_sw;
                win_stage  = ($urandom_range(0, 24) == 0);
                player_hit = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 59) == 0) begin
                    win_stage  = 1'b1;
                    player_hit = 1'b1;
                end
                model_step(start_frame, start_game, pause_sw, win_stage, player_hit);
            end
        end

        @(negedge clk);
        check_outputs();
        check_value("mid_banner_resets", (resets_done > 0) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
